data_router_arbiter: RTL
========================

DATA_ROUTER_ARBITER -- requirements
Module: data_router_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of every data bus.
REQ-002 SHALL have parameter BURST_MAX, default 4, maximum beats per grant (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports in_axi_data_k, input, DATA_WIDTH, stream k data (k = 1,2,3).
REQ-006 SHALL have ports in_axi_valid_k, input, 1, stream k valid.
REQ-007 SHALL have ports in_axi_ready_k, output, 1, stream k ready.
REQ-008 SHALL have port m_axi_data, output, DATA_WIDTH, merged data.
REQ-009 SHALL have port m_axi_id, output, 2, source stream of the current beat (1,2,3; 0 never driven while valid).
REQ-010 SHALL have port m_axi_valid, output, 1, merged valid.
REQ-011 SHALL have port m_axi_ready, input, 1, downstream ready.

Function
REQ-012 SHALL merge the three router output streams into one stream by round-robin arbitration with burst grants.
REQ-013 SHALL implement FSM states IDLE and GRANT; reset enters IDLE.
REQ-014 IDLE: when any in_axi_valid_k is high, grant the first requester searching from rr_ptr upward (wrap 3->1); enter GRANT next cycle; no in_axi_ready asserted in IDLE.
REQ-015 SHALL hold the output in a one-entry register slice; slot_free = !m_axi_valid || m_axi_ready.
REQ-016 GRANT: in_axi_ready_g = slot_free for the granted stream g only; other readys 0.
REQ-017 SHALL capture data and set m_axi_id = g on each in_valid_g && in_ready_g; m_axi_valid SHALL stay high until m_axi_ready, with data/id stable.
REQ-018 SHALL count beats per grant (4-bit); grant ends on the beat where count reaches BURST_MAX, or in the first GRANT cycle with in_axi_valid_g low; next state IDLE.
REQ-019 On grant end SHALL set rr_ptr = g+1 (wrap 3->1) and clear the beat count.
REQ-020 Latency: valid in IDLE at cycle n -> in_axi_ready at n+1 (slot free) -> m_axi_valid at n+2.
REQ-021 Back-pressure: m_axi_ready low SHALL hold in_axi_ready_g low once the slot is full; no beat lost or duplicated.
REQ-022 Simultaneous requests SHALL be served in rr order; a lone requester SHALL be re-granted after one IDLE cycle.
REQ-023 Simultaneous slot drain and fill SHALL be a single-cycle replace (full throughput within a grant).

Reset
REQ-024 Reset SHALL force: state IDLE, rr_ptr = 1, beat count 0, m_axi_valid 0, m_axi_id 0, m_axi_data 0, all in_axi_ready_k 0.
REQ-025 Reset mid-burst SHALL discard the slice contents and the grant; behaviour resumes as from power-up the cycle after reset deasserts.

Configuration
REQ-026 Macro DATA_ROUTER_ARB_STATS_EN: when defined, SHALL add outputs beat_count_1/2/3 (16-bit, wrap at 65535->0), each incremented per accepted input beat of that stream, reset to 0; when undefined these ports and counters SHALL not exist and function is otherwise identical.

Verification
REQ-027 Reset with all valids high -> all readys 0, m_axi_valid 0, m_axi_id 0 throughout reset.
REQ-028 Only stream 2 sends 6 beats 0x20..0x25, m_axi_ready=1 -> output 0x20..0x23 with id 2, one IDLE gap, then 0x24,0x25 id 2.
REQ-029 All three streams valid continuously, BURST_MAX=4 -> id sequence 1x4, 2x4, 3x4, 1x4; each burst contiguous.
REQ-030 Stream 1 burst with m_axi_ready low 3 cycles mid-burst -> m_axi_data/id stable, in_axi_ready_1 low, no loss/duplication.
REQ-031 Stream 3 drops valid after 2 beats -> grant ends, rr_ptr=1, waiting stream 1 granted next.
REQ-032 With DATA_ROUTER_ARB_STATS_EN, 10 beats from stream 1 and 3 from stream 3 -> beat_count_1=10, beat_count_2=0, beat_count_3=3.

Source files
------------

// File: rtl/data_router_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_router_arbiter
// Brief    : Round-robin burst arbiter merging three streams into one stream
//            through a one-entry output register slice. Optional per-stream
//            beat counters are enabled by DATA_ROUTER_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module data_router_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_axi_data_1,
    input  logic                  in_axi_valid_1,
    output logic                  in_axi_ready_1,
    input  logic [DATA_WIDTH-1:0] in_axi_data_2,
    input  logic                  in_axi_valid_2,
    output logic                  in_axi_ready_2,
    input  logic [DATA_WIDTH-1:0] in_axi_data_3,
    input  logic                  in_axi_valid_3,
    output logic                  in_axi_ready_3,
    output logic [DATA_WIDTH-1:0] m_axi_data,
    output logic [1:0]            m_axi_id,
    output logic                  m_axi_valid,
    input  logic                  m_axi_ready
`ifdef DATA_ROUTER_ARB_STATS_EN
    ,
    output logic [15:0]           beat_count_1,
    output logic [15:0]           beat_count_2,
    output logic [15:0]           beat_count_3
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] c_BURST_LAST = 4'(BURST_MAX - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_grant;
    logic [1:0]            r_rr_ptr;
    logic [3:0]            r_beat_cnt;
    logic                  r_m_valid;
    logic [1:0]            r_m_id;
    logic [DATA_WIDTH-1:0] r_m_data;

    logic [2:0]            w_req;
    logic [1:0]            w_pick;
    logic                  w_gnt_valid;
    logic [DATA_WIDTH-1:0] w_gnt_data;
    logic                  w_slot_free;
    logic                  w_grant_on;
    logic                  w_in_fire;
    logic                  w_grant_end;

    assign w_req       = {in_axi_valid_3, in_axi_valid_2, in_axi_valid_1};
    assign w_slot_free = !r_m_valid || m_axi_ready;
    // Readys are gated by reset so they are low from the first reset cycle.
    assign w_grant_on  = !reset && (r_state == ST_GRANT) && w_slot_free;
    assign w_in_fire   = w_grant_on && w_gnt_valid;
    assign w_grant_end = (r_state == ST_GRANT) &&
                         (!w_gnt_valid || (w_in_fire && (r_beat_cnt == c_BURST_LAST)));

    assign in_axi_ready_1 = w_grant_on && (r_grant == 2'd1);
    assign in_axi_ready_2 = w_grant_on && (r_grant == 2'd2);
    assign in_axi_ready_3 = w_grant_on && (r_grant == 2'd3);

    assign m_axi_data  = r_m_data;
    assign m_axi_id    = r_m_id;
    assign m_axi_valid = r_m_valid;

    // First requester at or after rr_ptr, wrapping 3 -> 1.
    always_comb begin
        w_pick = 2'd0;
        case (r_rr_ptr)
            2'd2:    w_pick = w_req[1] ? 2'd2 : w_req[2] ? 2'd3 : w_req[0] ? 2'd1 : 2'd0;
            2'd3:    w_pick = w_req[2] ? 2'd3 : w_req[0] ? 2'd1 : w_req[1] ? 2'd2 : 2'd0;
            default: w_pick = w_req[0] ? 2'd1 : w_req[1] ? 2'd2 : w_req[2] ? 2'd3 : 2'd0;
        endcase
    end

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_data  = '0;
        case (r_grant)
            2'd1:    begin w_gnt_valid = in_axi_valid_1; w_gnt_data = in_axi_data_1; end
            2'd2:    begin w_gnt_valid = in_axi_valid_2; w_gnt_data = in_axi_data_2; end
            2'd3:    begin w_gnt_valid = in_axi_valid_3; w_gnt_data = in_axi_data_3; end
            default: begin w_gnt_valid = 1'b0;           w_gnt_data = '0;            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|w_req)      w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_grant_end) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'd0;
            r_rr_ptr   <= 2'd1;
            r_beat_cnt <= 4'd0;
            r_m_valid  <= 1'b0;
            r_m_id     <= 2'd0;
            r_m_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && (|w_req)) begin
                r_grant <= w_pick;
            end
            // Fill wins over drain so a simultaneous drain/fill is a replace.
            if (w_in_fire) begin
                r_m_data  <= w_gnt_data;
                r_m_id    <= r_grant;
                r_m_valid <= 1'b1;
            end else if (m_axi_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_grant_end) begin
                r_beat_cnt <= 4'd0;
                r_rr_ptr   <= (r_grant == 2'd3) ? 2'd1 : r_grant + 2'd1;
            end else if (w_in_fire) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
            end
        end
    end

`ifdef DATA_ROUTER_ARB_STATS_EN
    logic [15:0] r_stat_1;
    logic [15:0] r_stat_2;
    logic [15:0] r_stat_3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_1 <= 16'd0;
            r_stat_2 <= 16'd0;
            r_stat_3 <= 16'd0;
        end else begin
            if (in_axi_valid_1 && in_axi_ready_1) r_stat_1 <= r_stat_1 + 16'd1;
            if (in_axi_valid_2 && in_axi_ready_2) r_stat_2 <= r_stat_2 + 16'd1;
            if (in_axi_valid_3 && in_axi_ready_3) r_stat_3 <= r_stat_3 + 16'd1;
        end
    end

    assign beat_count_1 = r_stat_1;
    assign beat_count_2 = r_stat_2;
    assign beat_count_3 = r_stat_3;
`endif

endmodule
`default_nettype wire
